// File: rtl/rv32_pkg.sv
// rv32_pkg -- definitions shared by the RV32 front-end blocks.
//   XLEN            : architectural register / address width
//   INSTR_NOP       : canonical NOP (addi x0,x0,0) used for F/D bubbles
//   INSTR_EBREAK    : EBREAK encoding that starts the halt drain
//   fetch_state_t   : RUN / DRAIN / DONE states of the fetch halt machine
//   align_pc()      : forces a target address onto a word boundary
package rv32_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] INSTR_NOP    = 32'h0000_0013;
    localparam logic [XLEN-1:0] INSTR_EBREAK = 32'h0010_0073;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } fetch_state_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if -- bus bundle between the fetch stage and its surroundings
// (hazard unit, execute redirect, instruction memory, decode).
//   stall_i        : hold PC and F/D
//   redirect_i     : taken branch/jump from execute
//   redirect_pc_i  : redirect target (low two bits ignored)
//   imem_addr_o    : instruction memory address (current PC)
//   imem_rdata_i   : combinational instruction word at imem_addr_o
//   pc_f_o         : PC of the instruction in F/D
//   instr_f_o      : instruction in F/D
//   valid_f_o      : F/D holds a real instruction (0 = bubble)
//   halt_o         : EBREAK fetched, draining or drained
//   done_o         : drain complete
// Modports: master = fetch stage, slave = environment.
interface fetch_stage_if;
    import rv32_pkg::*;

    logic            stall_i;
    logic            redirect_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic [XLEN-1:0] imem_addr_o;
    logic [XLEN-1:0] imem_rdata_i;
    logic [XLEN-1:0] pc_f_o;
    logic [XLEN-1:0] instr_f_o;
    logic            valid_f_o;
    logic            halt_o;
    logic            done_o;

    modport master (
        input  stall_i, redirect_i, redirect_pc_i, imem_rdata_i,
        output imem_addr_o, pc_f_o, instr_f_o, valid_f_o, halt_o, done_o
    );

    modport slave (
        output stall_i, redirect_i, redirect_pc_i, imem_rdata_i,
        input  imem_addr_o, pc_f_o, instr_f_o, valid_f_o, halt_o, done_o
    );

endinterface

// File: rtl/fetch_halt_fsm.sv
// fetch_halt_fsm -- EBREAK halt sequencer for the fetch stage.
// After an EBREAK is fetched the machine sits in DRAIN for DRAIN_CYCLES
// non-stalled cycles so the younger pipeline stages empty out, then parks
// in DONE until reset. A redirect during DRAIN means the EBREAK was on a
// wrong path, so fetching resumes.
// Optional feature macro: FETCH_HALT_EN. Without it the machine is absent:
// state is constantly RUN and halt_o/done_o are tied low.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   stall_i         : stall from decode
//   redirect_i      : redirect from execute
//   fetch_ebreak_i  : current imem word is EBREAK
//   state_o         : current state (RUN/DRAIN/DONE)
//   halt_o, done_o  : registered status outputs
module fetch_halt_fsm
    import rv32_pkg::*;
#(
    parameter int DRAIN_CYCLES = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall_i,
    input  logic         redirect_i,
    input  logic         fetch_ebreak_i,
    output fetch_state_t state_o,
    output logic         halt_o,
    output logic         done_o
);

`ifdef FETCH_HALT_EN
    localparam int CNT_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DRAIN_CYCLES);

    fetch_state_t     state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             halt_reg;
    logic             done_reg;

    assign cnt_next = cnt_reg + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_RUN;
            cnt_reg   <= '0;
            halt_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (!redirect_i && !stall_i && fetch_ebreak_i) begin
                        state_reg <= ST_DRAIN;
                        cnt_reg   <= '0;
                        halt_reg  <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (redirect_i) begin
                        // EBREAK was fetched down a mispredicted path
                        state_reg <= ST_RUN;
                        cnt_reg   <= '0;
                        halt_reg  <= 1'b0;
                    end else if (!stall_i) begin
                        cnt_reg <= cnt_next;
                        // >= keeps a zero-length drain from hanging here
                        if (cnt_next >= CNT_TARGET) begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    // terminal: only reset leaves DONE
                end
                default: begin
                    state_reg <= ST_RUN;
                    cnt_reg   <= '0;
                    halt_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign state_o = state_reg;
    assign halt_o  = halt_reg;
    assign done_o  = done_reg;
`else
    assign state_o = ST_RUN;
    assign halt_o  = 1'b0;
    assign done_o  = 1'b0;

    wire unused_inputs = &{1'b0, clk, rst, stall_i, redirect_i, fetch_ebreak_i};
`endif

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage -- RV32 instruction fetch: PC register, instruction memory
// addressing and the F/D pipeline register, with an optional EBREAK halt
// drain (macro FETCH_HALT_EN; disabled by default, in which case EBREAK is
// fetched like any other instruction).
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-high reset
//   bus  : fetch_stage_if.master (stall/redirect in, imem bus, F/D out,
//          halt/done status)
// Parameters:
//   RESET_PC     : PC loaded on reset
//   DRAIN_CYCLES : non-stalled cycles from EBREAK fetch to done
module fetch_stage
    import rv32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC     = 32'h0000_0000,
    parameter int              DRAIN_CYCLES = 5
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);

`ifdef FETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] pc_f_reg;
    logic [XLEN-1:0] instr_f_reg;
    logic            valid_f_reg;
    fetch_state_t    state;
    logic            halt;
    logic            done;
    logic            is_ebreak;

    assign is_ebreak = (bus.imem_rdata_i == INSTR_EBREAK);

    fetch_halt_fsm #(
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) u_halt_fsm (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (bus.stall_i),
        .redirect_i     (bus.redirect_i),
        .fetch_ebreak_i (is_ebreak),
        .state_o        (state),
        .halt_o         (halt),
        .done_o         (done)
    );

    // Priority: DONE (ignores everything) > redirect > stall > normal.
    // pc_f_reg is left alone on bubbles; it is only meaningful with valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg      <= RESET_PC;
            pc_f_reg    <= RESET_PC;
            instr_f_reg <= INSTR_NOP;
            valid_f_reg <= 1'b0;
        end else if (state == ST_DONE) begin
            instr_f_reg <= INSTR_NOP;
            valid_f_reg <= 1'b0;
        end else if (bus.redirect_i) begin
            pc_reg      <= align_pc(bus.redirect_pc_i);
            instr_f_reg <= INSTR_NOP;
            valid_f_reg <= 1'b0;
        end else if (!bus.stall_i) begin
            if (state == ST_DRAIN) begin
                instr_f_reg <= INSTR_NOP;
                valid_f_reg <= 1'b0;
            end else begin
                pc_f_reg    <= pc_reg;
                instr_f_reg <= bus.imem_rdata_i;
                valid_f_reg <= 1'b1;
                // With halting enabled the PC freezes on the EBREAK itself
                if (!(HALT_EN && is_ebreak)) begin
                    pc_reg <= pc_reg + XLEN'(4);
                end
            end
        end
    end

    assign bus.imem_addr_o = pc_reg;
    assign bus.pc_f_o      = pc_f_reg;
    assign bus.instr_f_o   = instr_f_reg;
    assign bus.valid_f_o   = valid_f_reg;
    assign bus.halt_o      = halt;
    assign bus.done_o      = done;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC loaded on reset.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 5, the number of non-stalled cycles from halt fetch to done.
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have port stall_i  in  1  hold PC and F/D register (hazard from decode).
REQ-006 SHALL have port redirect_i  in  1  taken branch/jump from execute.
REQ-007 SHALL have port redirect_pc_i  in  32  redirect target.
REQ-008 SHALL have port imem_addr_o  out  32  instruction memory address, equal to current PC.
REQ-009 SHALL have port imem_rdata_i  in  32  instruction word, combinational read of imem_addr_o.
REQ-010 SHALL have port pc_f_o  out  32  PC of the instruction held in F/D.
REQ-011 SHALL have port instr_f_o  out  32  instruction held in F/D.
REQ-012 SHALL have port valid_f_o  out  1  F/D holds a real instruction (0 = bubble).
REQ-013 SHALL have port halt_o  out  1  EBREAK fetched, draining or drained.
REQ-014 SHALL have port done_o  out  1  drain complete; pipeline quiescent.

Function
REQ-015 SHALL drive imem_addr_o from the PC register with zero added latency.
REQ-016 SHALL, on a cycle with stall_i=0 and no redirect in RUN, load F/D with {pc, imem_rdata_i, valid=1} and advance PC by 4, wrapping 32'hFFFF_FFFC to 32'h0000_0000.
REQ-017 SHALL, when stall_i=1 and redirect_i=0, hold PC and F/D unchanged.
REQ-018 SHALL give redirect_i priority over stall_i: PC <= {redirect_pc_i[31:2],2'b00}, F/D <= NOP (32'h0000_0013), valid_f_o=0.
REQ-019 SHALL implement states RUN, DRAIN, DONE.
REQ-020 SHALL, in RUN with imem_rdata_i=32'h0010_0073 (EBREAK), no stall, no redirect: latch EBREAK into F/D with valid=1, hold PC, go to DRAIN, clear drain counter.
REQ-021 SHALL, in DRAIN/DONE, hold PC and load F/D with NOP, valid=0, on every non-stalled cycle.
REQ-022 SHALL increment the drain counter only on non-stalled DRAIN cycles and move to DONE when it reaches DRAIN_CYCLES.
REQ-023 SHALL, on redirect_i in DRAIN (EBREAK on wrong path), return to RUN, clear the counter, apply REQ-018.
REQ-024 SHALL ignore redirect_i and stall_i in DONE; DONE is left only by reset.
REQ-025 SHALL assert halt_o in DRAIN and DONE, done_o in DONE only, both registered.

Reset
REQ-026 SHALL on rst=1 asynchronously set PC=RESET_PC, pc_f_o=RESET_PC, instr_f_o=NOP, valid_f_o=0, state=RUN, counter=0, halt_o=0, done_o=0.
REQ-027 SHALL, on reset asserted mid-DRAIN, abandon the drain; first fetch after release is RESET_PC.

Configuration
REQ-028 SHALL, with FETCH_HALT_EN defined, implement REQ-019..REQ-025.
REQ-029 SHALL, without FETCH_HALT_EN, treat EBREAK as an ordinary instruction, remain in RUN, tie halt_o and done_o to 0.

Structure
REQ-030 SHALL take NOP, EBREAK encodings, XLEN and the RUN/DRAIN/DONE state enum from the shared package rv32_pkg.
REQ-031 SHALL place state machine and drain counter in sub-module fetch_halt_fsm; PC and F/D registers stay in fetch_stage.

Verification
REQ-032 Reset release, sequential ADDIs at 0x0,0x4,0x8 -> pc_f_o 0x0,0x4,0x8 on successive cycles, valid_f_o=1.
REQ-033 stall_i=1 for 3 cycles at PC 0x8 -> imem_addr_o, pc_f_o, instr_f_o constant; resumes with 0xC.
REQ-034 redirect_i=1, redirect_pc_i=0x103 with stall_i=1 -> next imem_addr_o=0x100, instr_f_o=0x13, valid_f_o=0.
REQ-035 EBREAK at 0x20 -> instr_f_o=0x0010_0073, halt_o=1 next cycle, done_o=1 exactly 5 non-stalled cycles later, PC frozen at 0x20.
REQ-036 EBREAK at 0x20 then redirect to 0x40 in second DRAIN cycle -> halt_o=0, fetch resumes at 0x40, done_o never asserts.
REQ-037 rst pulsed mid-DRAIN -> all outputs at reset values immediately, fetch restarts at RESET_PC.
